filter_fir_core: RTL and testbench
==================================

FILTER_FIR_CORE -- requirements
Module: filter_fir_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel (signed).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width (signed).
REQ-003 SHALL have parameter TAPS, default 512, filter length; power of two, 4..1024.
REQ-004 SHALL have parameter CHANNELS, default 2, channels packed in one sample word; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-005 SHALL have parameter ACC_W, default 40, accumulator/output width per channel; at least DATA_W+COEF_W.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have port filter_aud_in_rts  input  1  upstream sample valid.
REQ-009 SHALL have port filter_aud_in_rtr  output  1  block ready for a sample.
REQ-010 SHALL have port filter_aud_in  input  CHANNELS*DATA_W  input sample word.
REQ-011 SHALL have port filter_aud_out_rts  output  1  result valid.
REQ-012 SHALL have port filter_aud_out_rtr  input  1  downstream ready.
REQ-013 SHALL have port filter_aud_out  output  CHANNELS*ACC_W  result word, same channel packing.
REQ-014 SHALL have port coef_re  output  1  coefficient read enable.
REQ-015 SHALL have port coef_rdptr  output  log2(TAPS)  coefficient index k.
REQ-016 SHALL have port rf_filter_coeff  input  COEF_W  coefficient h[k], valid the cycle after coef_re.
REQ-017 SHALL have port busy  output  1  high in any state but IDLE.

Function
REQ-018 SHALL implement one-hot states IDLE, WRITE, MAC, DRAIN, OUT.
REQ-019 Input transfer SHALL occur when filter_aud_in_rts and filter_aud_in_rtr are both high at a clock edge; filter_aud_in_rtr SHALL be high only in IDLE.
REQ-020 IDLE->WRITE on input transfer; WRITE stores the sample into an internal TAPS-deep circular history at wr_ptr, then ->MAC.
REQ-021 MAC SHALL last exactly TAPS cycles, issuing coef_re=1 with coef_rdptr=k and history read of entry (wr_ptr-k) mod TAPS, k=0..TAPS-1.
REQ-022 Each product x*h SHALL be formed one cycle after its read (full DATA_W+COEF_W signed), sign-extended to ACC_W and accumulated per channel; k=0 product loads, later ones add.
REQ-023 DRAIN SHALL last one cycle, accumulating the k=TAPS-1 product, then ->OUT.
REQ-024 OUT SHALL hold filter_aud_out_rts=1 and filter_aud_out stable until filter_aud_out_rtr=1 at an edge, then ->IDLE, advancing wr_ptr by 1 mod TAPS.
REQ-025 filter_aud_out_rts SHALL first be high TAPS+3 cycles after the input-transfer edge when filter_aud_out_rtr is already high.
REQ-026 A fill counter (saturating at TAPS) SHALL count accepted samples; taps with k >= fill count SHALL contribute zero (history is not cleared).
REQ-027 Accumulation SHALL wrap modulo 2^ACC_W unless FILTER_SAT_EN is defined.
REQ-028 Input rts while not in IDLE SHALL be ignored (not accepted, not lost upstream, since rtr=0).
REQ-029 coef_re SHALL be 0 outside MAC; coef_rdptr SHALL hold 0 outside MAC.

Reset
REQ-030 On rst high, asynchronously: state=IDLE, wr_ptr=0, fill count=0, accumulators=0, filter_aud_out=0, filter_aud_out_rts=0, coef_re=0, coef_rdptr=0, busy=0, filter_aud_in_rtr=0.
REQ-031 filter_aud_in_rtr SHALL rise on the first clock edge after rst deasserts.
REQ-032 rst mid-MAC or mid-OUT SHALL abandon the result; no output handshake follows.

Configuration
REQ-033 Macro FILTER_SAT_EN: when defined, each channel accumulator SHALL clamp to +(2^(ACC_W-1))-1 / -(2^(ACC_W-1)) on overflow and hold clamped until next load; when undefined, REQ-027 wrap applies and no clamp logic exists.

Verification
REQ-034 TAPS=8, h[k]=k+1, reset, single sample ch0=0x0100 ch1=0xFF00 -> out ch0=256, ch1=-256; rts at cycle 11 after transfer.
REQ-035 TAPS=8, h[k]=1, eight samples of 0x0001 then ninth 0x0001 -> outputs 1,2,...,8,8 (fill counter and wrap).
REQ-036 Impulse 0x7FFF then zeros, h[k]=k+1, TAPS=8 -> outputs 32767*1..32767*8 then 0 (pointer wrap after 8).
REQ-037 Out_rtr low 20 cycles in OUT -> rts and data stable, in_rtr=0, rts held input not consumed until after release.
REQ-038 ACC_W=32, TAPS=4, all x=h=-32768 -> with FILTER_SAT_EN out=0x7FFFFFFF; without, out=0x00000000 (wrapped).
REQ-039 rst pulse at MAC cycle 3 -> all outputs at reset values within same cycle; next sample gives single-tap result.

Source files
------------

// File: rtl/filter_fir_core.sv
// Multi-channel serial-MAC FIR: one sample in, TAPS coefficient fetches, one result out.
// Optional FILTER_SAT_EN macro clamps each channel accumulator instead of wrapping.

module filter_fir_lane #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_x,
  input  logic [COEF_W-1:0] i_h,
  input  logic              i_vld,
  input  logic              i_first,
  output logic [ACC_W-1:0]  o_acc_nxt
);
  localparam int P_W = DATA_W + COEF_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_nxt;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = $signed(i_x) * $signed(i_h);
  assign w_ext  = ACC_W'(w_prod);

`ifdef FILTER_SAT_EN
  logic signed [ACC_W:0] w_sum;
  logic                  w_ovf;
  logic                  w_hold_nxt;
  logic                  r_hold;

  assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_ext);
  assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // Once clamped, the lane sticks at the rail until the next k=0 load.
  always_comb begin
    w_nxt      = w_sum[ACC_W-1:0];
    w_hold_nxt = r_hold;
    if (i_first) begin
      w_nxt      = w_ext;
      w_hold_nxt = 1'b0;
    end else if (r_hold) begin
      w_nxt = r_acc;
    end else if (w_ovf) begin
      w_nxt      = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      w_hold_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_hold <= 1'b0;
    else if (i_vld) r_hold <= w_hold_nxt;
  end
`else
  assign w_nxt = i_first ? w_ext : r_acc + w_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (i_vld) r_acc <= w_nxt;
  end

  assign o_acc_nxt = w_nxt;
endmodule

module filter_fir_core #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 512,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        filter_aud_in_rts,
  output logic                        filter_aud_in_rtr,
  input  logic [CHANNELS*DATA_W-1:0]  filter_aud_in,
  output logic                        filter_aud_out_rts,
  input  logic                        filter_aud_out_rtr,
  output logic [CHANNELS*ACC_W-1:0]   filter_aud_out,
  output logic                        coef_re,
  output logic [$clog2(TAPS)-1:0]     coef_rdptr,
  input  logic [COEF_W-1:0]           rf_filter_coeff,
  output logic                        busy
);
  localparam int PTR_W = $clog2(TAPS);
  localparam int W     = CHANNELS * DATA_W;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WRITE = 5'b00010,
    S_MAC   = 5'b00100,
    S_DRAIN = 5'b01000,
    S_OUT   = 5'b10000
  } state_t;

  state_t                          r_state;
  logic [PTR_W-1:0]                r_wr_ptr;
  logic [PTR_W:0]                  r_fill;
  logic [W-1:0]                    r_sample;
  logic [W-1:0]                    r_x;
  logic [W-1:0]                    r_hist [TAPS];
  logic                            r_prod_vld;
  logic                            r_first;
  logic                            r_in_rtr;
  logic                            r_out_rts;
  logic [CHANNELS*ACC_W-1:0]       r_out;
  logic                            r_coef_re;
  logic [PTR_W-1:0]                r_rdptr;
  logic                            r_busy;
  logic [PTR_W-1:0]                w_rd_idx;
  logic                            w_tap_live;
  logic                            w_xfer;
  logic [CHANNELS-1:0][ACC_W-1:0]  w_acc_nxt;

  assign w_xfer     = filter_aud_in_rts && r_in_rtr && (r_state == S_IDLE);
  assign w_rd_idx   = r_wr_ptr - r_rdptr;
  assign w_tap_live = ({1'b0, r_rdptr} < r_fill);

  // History is intentionally not reset; the fill count masks stale entries.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_hist[r_wr_ptr] <= r_sample;
    if (r_state == S_MAC)   r_x <= w_tap_live ? r_hist[w_rd_idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_vld <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_prod_vld <= (r_state == S_MAC);
      r_first    <= (r_state == S_MAC) && (r_rdptr == '0);
    end
  end

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
      filter_fir_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .i_x       (r_x[ch*DATA_W +: DATA_W]),
        .i_h       (rf_filter_coeff),
        .i_vld     (r_prod_vld),
        .i_first   (r_first),
        .o_acc_nxt (w_acc_nxt[ch])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_sample  <= '0;
      r_in_rtr  <= 1'b0;
      r_out_rts <= 1'b0;
      r_out     <= '0;
      r_coef_re <= 1'b0;
      r_rdptr   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_rtr <= !w_xfer;
          if (w_xfer) begin
            r_sample <= filter_aud_in;
            r_busy   <= 1'b1;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_fill != (PTR_W+1)'(TAPS)) r_fill <= r_fill + 1'b1;
          r_coef_re <= 1'b1;
          r_rdptr   <= '0;
          r_state   <= S_MAC;
        end
        S_MAC: begin
          if (r_rdptr == PTR_W'(TAPS-1)) begin
            r_coef_re <= 1'b0;
            r_rdptr   <= '0;
            r_state   <= S_DRAIN;
          end else begin
            r_rdptr <= r_rdptr + 1'b1;
          end
        end
        S_DRAIN: begin
          // Last product lands this cycle; capture the post-add value directly.
          r_out     <= w_acc_nxt;
          r_out_rts <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (filter_aud_out_rtr) begin
            r_out_rts <= 1'b0;
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_busy    <= 1'b0;
            r_in_rtr  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_coef_re <= 1'b0;
          r_rdptr   <= '0;
          r_out_rts <= 1'b0;
          r_busy    <= 1'b0;
          r_in_rtr  <= 1'b0;
        end
      endcase
    end
  end

  assign filter_aud_in_rtr  = r_in_rtr;
  assign filter_aud_out_rts = r_out_rts;
  assign filter_aud_out     = r_out;
  assign coef_re            = r_coef_re;
  assign coef_rdptr         = r_rdptr;
  assign busy               = r_busy;
endmodule

// File: tb/tb_filter_fir_core.sv
// Directed bench: 8-tap stereo core plus a 4-tap 32-bit-accumulator core for overflow.
module tb_filter_fir_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_rts, a_in_rtr, a_out_rts, a_out_rtr, a_coef_re, a_busy;
  logic [31:0] a_in;
  logic [79:0] a_out;
  logic [2:0]  a_rdptr;
  logic [15:0] a_h;
  int          coef_mode;

  logic        b_in_rts, b_in_rtr, b_out_rts, b_coef_re, b_busy;
  logic        b_out_rtr = 1'b1;
  logic [15:0] b_in;
  logic [31:0] b_out;
  logic [1:0]  b_rdptr;
  logic [15:0] b_h = 16'h8000;

  int checks = 0;
  int errors = 0;

  // Coefficient store: h[k]=k+1 (mode 0) or h[k]=1 (mode 1), one cycle read latency
  always_ff @(posedge clk)
    if (a_coef_re) a_h <= (coef_mode == 0) ? 16'(a_rdptr) + 16'd1 : 16'd1;

  filter_fir_core #(.DATA_W(16), .COEF_W(16), .TAPS(8), .CHANNELS(2), .ACC_W(40)) dut_a (
    .clk(clk), .rst(rst),
    .filter_aud_in_rts(a_in_rts), .filter_aud_in_rtr(a_in_rtr), .filter_aud_in(a_in),
    .filter_aud_out_rts(a_out_rts), .filter_aud_out_rtr(a_out_rtr), .filter_aud_out(a_out),
    .coef_re(a_coef_re), .coef_rdptr(a_rdptr), .rf_filter_coeff(a_h), .busy(a_busy)
  );

  filter_fir_core #(.DATA_W(16), .COEF_W(16), .TAPS(4), .CHANNELS(1), .ACC_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .filter_aud_in_rts(b_in_rts), .filter_aud_in_rtr(b_in_rtr), .filter_aud_in(b_in),
    .filter_aud_out_rts(b_out_rts), .filter_aud_out_rtr(b_out_rtr), .filter_aud_out(b_out),
    .coef_re(b_coef_re), .coef_rdptr(b_rdptr), .rf_filter_coeff(b_h), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_rts = 1'b0;
    b_in_rts = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample to dut_a, return the result word and the cycle rts rose
  task automatic a_send(input logic [31:0] d, output logic [79:0] o, output int cyc);
    int n;
    a_in = d;
    a_in_rts = 1'b1;
    n = 0;
    while (!a_in_rtr && n < 200) begin @(negedge clk); n++; end
    if (!a_in_rtr) chk("in_rtr_wait", a_in_rtr, 1);
    @(posedge clk); #1 a_in_rts = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!a_out_rts && n < 200);
    chk("out_rts_wait", a_out_rts, 1);
    o = a_out;
    cyc = n + 1;
  endtask

  logic [79:0] o;
  logic [39:0] e;
  int          cyc;

  initial begin
    a_in = '0; b_in = '0; a_out_rtr = 1'b1; coef_mode = 0;
    rst = 1'b1; a_in_rts = 1'b0; b_in_rts = 1'b0;
    #3;
    chk("rst_in_rtr", a_in_rtr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_rts", a_out_rts, 0);
    chk("rst_coef_re", a_coef_re, 0);
    chk("rst_rdptr", a_rdptr, 0);
    chk("rst_out", a_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rtr_pre_edge", a_in_rtr, 0);
    @(posedge clk); #1 chk("rtr_first_edge", a_in_rtr, 1);

    // single sample, h[k]=k+1
    @(negedge clk);
    a_send({16'hFF00, 16'h0100}, o, cyc);
    chk("single_cyc", cyc, 11);
    chk("single_ch0", o[39:0], 40'd256);
    e = -40'sd256;
    chk("single_ch1", o[79:40], e);
    chk("out_busy", a_busy, 1);
    chk("out_coef_re", a_coef_re, 0);
    chk("out_rdptr", a_rdptr, 0);
    chk("out_in_rtr", a_in_rtr, 0);

    // fill counter growth and saturation, h[k]=1
    do_reset();
    coef_mode = 1;
    for (int i = 1; i <= 9; i++) begin
      a_send({16'd1, 16'd1}, o, cyc);
      chk($sformatf("fill_ch0_%0d", i), o[39:0], (i < 8) ? i : 8);
      chk($sformatf("fill_ch1_%0d", i), o[79:40], (i < 8) ? i : 8);
    end

    // impulse walks through taps, overwritten after pointer wrap
    do_reset();
    coef_mode = 0;
    for (int i = 1; i <= 9; i++) begin
      a_send((i == 1) ? 32'h0000_7FFF : 32'h0, o, cyc);
      chk($sformatf("imp_ch0_%0d", i), o[39:0], (i <= 8) ? 32767 * i : 0);
      chk($sformatf("imp_ch1_%0d", i), o[79:40], 0);
    end

    // downstream stall with a pending upstream sample
    do_reset();
    a_out_rtr = 1'b0;
    a_send({16'd2, 16'd2}, o, cyc);
    chk("stall_first", o, {40'd2, 40'd2});
    a_in = {16'd3, 16'd3};
    a_in_rts = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall_rts", a_out_rts, 1);
      chk("stall_data", a_out, {40'd2, 40'd2});
      chk("stall_in_rtr", a_in_rtr, 0);
    end
    @(negedge clk) a_out_rtr = 1'b1;
    a_send({16'd3, 16'd3}, o, cyc);
    chk("stall_next", o, {40'd7, 40'd7});

    // reset in the middle of MAC
    do_reset();
    a_send({16'd0, 16'd5}, o, cyc);
    chk("pre_rst", o[39:0], 40'd5);
    @(negedge clk);
    a_in = {16'd0, 16'd7};
    a_in_rts = 1'b1;
    while (!a_in_rtr) @(negedge clk);
    @(posedge clk); #1 a_in_rts = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mac3_rdptr", a_rdptr, 2);
    rst = 1'b1;
    #1;
    chk("mrst_coef_re", a_coef_re, 0);
    chk("mrst_rdptr", a_rdptr, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_in_rtr", a_in_rtr, 0);
    chk("mrst_out_rts", a_out_rts, 0);
    chk("mrst_out", a_out, 0);
    @(negedge clk) rst = 1'b0;
    a_send({16'd0, 16'd9}, o, cyc);
    chk("post_rst", o[39:0], 40'd9);

    // overflow on the 32-bit accumulator core
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      int n;
      b_in = 16'h8000;
      b_in_rts = 1'b1;
      n = 0;
      while (!b_in_rtr && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1 b_in_rts = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b_out_rts && n < 200);
      chk("b_rts_wait", b_out_rts, 1);
      if (i == 1) chk("ovf_1", b_out, 32'h4000_0000);
`ifdef FILTER_SAT_EN
      if (i == 2) chk("ovf_2", b_out, 32'h7FFF_FFFF);
      if (i == 4) chk("ovf_4", b_out, 32'h7FFF_FFFF);
`else
      if (i == 2) chk("ovf_2", b_out, 32'h8000_0000);
      if (i == 4) chk("ovf_4", b_out, 32'h0000_0000);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
